// File: rtl/calc_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_disp_pkg
//  Description : Shared display codes and conversion FSM state encoding for
//                the calculator display path (binary-to-BCD converter and
//                the four-digit display multiplexer).
//                  BLANK_CODE   - digit position shows nothing
//                  ERR_CODE     - digit position shows the error glyph
//                  MAX_DISP_VAL - largest value a four-digit display shows
//                  conv_state_t - IDLE / SHIFT / DONE converter states
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_disp_pkg;

    localparam logic [7:0]  BLANK_CODE   = 8'h0F;
    localparam logic [7:0]  ERR_CODE     = 8'h0E;
    localparam int unsigned MAX_DISP_VAL = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage : calc_disp_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble correction cell. Adds 3 to a BCD nibble when
//                it is 5 or more, so that the following left shift carries
//                correctly into the next decimal digit.
//  Ports       : i_nib  [3:0]  nibble before correction
//                o_nib  [3:0]  corrected nibble
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bcd_digit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_gen
//  Description : Sequential binary-to-BCD converter (shift-and-add-3). Turns
//                an unsigned IN_W-bit value into four registered display
//                digit codes. Digits change only on the edge that finishes a
//                conversion, so downstream logic never sees a partial value.
//                Values above 9999 show ERR_CODE on all four digits with
//                overflow=1.
//  Ports       : clk_in            system clock, rising edge
//                rst               synchronous active-high reset
//                start             conversion request, honoured in IDLE only
//                bin_in [IN_W-1:0] value to convert, sampled with start
//                busy              high while SHIFT or DONE
//                done              one-cycle pulse, new digits valid
//                overflow          converted value exceeded 9999
//                digit1..digit4    ones..thousands as {4'h0,BCD} or a code
//  Config      : `define LEADING_ZERO_BLANK_EN to show leading zero digits
//                as BLANK_CODE (digit1 is never blanked).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_gen
    import calc_disp_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [7:0]      digit1,
    output logic [7:0]      digit2,
    output logic [7:0]      digit3,
    output logic [7:0]      digit4
);

    localparam int CNT_W = $clog2(IN_W + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] c_rst_upper = BLANK_CODE;
`else
    localparam logic [7:0] c_rst_upper = 8'h00;
`endif

    conv_state_t       r_state;
    conv_state_t       w_state_next;
    logic              w_load;
    logic              w_last;

    logic [IN_W-1:0]   r_shift;
    logic [15:0]       r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf_pend;

    logic [15:0]       w_acc_adj;
    logic [IN_W+15:0]  w_cat;
    logic [15:0]       w_acc_next;
    logic [IN_W-1:0]   w_shift_next;
    logic              w_in_ovf;

    logic [7:0]        w_dig1;
    logic [7:0]        w_dig2;
    logic [7:0]        w_dig3;
    logic [7:0]        w_dig4;

    logic [7:0]        r_digit1;
    logic [7:0]        r_digit2;
    logic [7:0]        r_digit3;
    logic [7:0]        r_digit4;
    logic              r_overflow;

    // ------------------------------------------------------------------
    // Add-3 correction on all four accumulator nibbles in parallel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_acc[4*g +: 4]),
            .o_nib (w_acc_adj[4*g +: 4])
        );
    end

    // The whole {accumulator, shift register} moves left by one; the bit
    // leaving nibble 3 falls off the top and only matters for values above
    // 9999, which overflow already reports.
    assign w_cat        = {w_acc_adj, r_shift} << 1;
    assign w_acc_next   = w_cat[IN_W+15:IN_W];
    assign w_shift_next = w_cat[IN_W-1:0];

    assign w_in_ovf = (32'(bin_in) > MAX_DISP_VAL);

    // ------------------------------------------------------------------
    // Digit codes formed from the final shifted accumulator
    // ------------------------------------------------------------------
    always_comb begin
        w_dig1 = {4'h0, w_acc_next[3:0]};
        w_dig2 = {4'h0, w_acc_next[7:4]};
        w_dig3 = {4'h0, w_acc_next[11:8]};
        w_dig4 = {4'h0, w_acc_next[15:12]};
`ifdef LEADING_ZERO_BLANK_EN
        // Blank from the top down until the first non-zero digit.
        if (w_acc_next[15:12] == 4'h0) begin
            w_dig4 = BLANK_CODE;
            if (w_acc_next[11:8] == 4'h0) begin
                w_dig3 = BLANK_CODE;
                if (w_acc_next[7:4] == 4'h0) begin
                    w_dig2 = BLANK_CODE;
                end
            end
        end
`endif
        if (r_ovf_pend) begin
            w_dig1 = ERR_CODE;
            w_dig2 = ERR_CODE;
            w_dig3 = ERR_CODE;
            w_dig4 = ERR_CODE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_digit1   <= 8'h00;
            r_digit2   <= c_rst_upper;
            r_digit3   <= c_rst_upper;
            r_digit4   <= c_rst_upper;
        end else if (w_load) begin
            r_shift    <= bin_in;
            r_acc      <= '0;
            r_cnt      <= CNT_W'(IN_W);
            r_ovf_pend <= w_in_ovf;
        end else if (r_state == SHIFT) begin
            r_shift <= w_shift_next;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_digit1   <= w_dig1;
                r_digit2   <= w_dig2;
                r_digit3   <= w_dig3;
                r_digit4   <= w_dig4;
                r_overflow <= r_ovf_pend;
            end
        end
    end

    assign overflow = r_overflow;
    assign digit1   = r_digit1;
    assign digit2   = r_digit2;
    assign digit3   = r_digit3;
    assign digit4   = r_digit4;

endmodule : bcd_digit_gen
`default_nettype wire

// File: tb/tb_bcd_digit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_digit_gen
//  Description : Scoreboard bench for bcd_digit_gen. Stimulus pushes the
//                hand-computed result and expected done cycle; a monitor
//                pops and compares on every done pulse and checks that the
//                outputs hold steady between pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_gen;
    import calc_disp_pkg::*;

    localparam int IN_W = 14;
    localparam int LAT  = IN_W;   // done cycle relative to the accept edge

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [32:0] RST_RES = {1'b0, 32'h0F0F0F00};
    localparam logic [32:0] EXP_0   = {1'b0, 32'h0F0F0F00};
    localparam logic [32:0] EXP_42  = {1'b0, 32'h0F0F0402};
    localparam logic [32:0] EXP_500 = {1'b0, 32'h0F050000};
    localparam logic [32:0] EXP_7   = {1'b0, 32'h0F0F0F07};
`else
    localparam logic [32:0] RST_RES = {1'b0, 32'h00000000};
    localparam logic [32:0] EXP_0   = {1'b0, 32'h00000000};
    localparam logic [32:0] EXP_42  = {1'b0, 32'h00000402};
    localparam logic [32:0] EXP_500 = {1'b0, 32'h00050000};
    localparam logic [32:0] EXP_7   = {1'b0, 32'h00000007};
`endif
    localparam logic [32:0] EXP_ERR = {1'b1, 32'h0E0E0E0E};

    logic            clk_in = 1'b0;
    logic            rst;
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [7:0]      digit1;
    logic [7:0]      digit2;
    logic [7:0]      digit3;
    logic [7:0]      digit4;

    bcd_digit_gen #(.IN_W(IN_W)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [32:0] res;
        int          dcyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic        stable_en = 1'b0;
    logic [32:0] last;

    function automatic logic [32:0] res_now();
        return {overflow, digit4, digit3, digit2, digit1};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on done, otherwise require outputs to hold.
    always @(negedge clk_in) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("digits", res_now(), mon_e.res);
                chk("done_cycle", 33'(cyc), 33'(mon_e.dcyc));
            end
            last = res_now();
        end else if (stable_en) begin
            chk("hold", res_now(), last);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Issue a single-cycle start and queue its expected result.
    task automatic do_start(input logic [IN_W-1:0] v, input logic [32:0] exp, output int acc);
        exp_t e;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_after_start", 33'(busy), 33'(1));
        acc    = cyc;
        e.res  = exp;
        e.dcyc = acc + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d want idle", busy, sb.size());
        end
    endtask

    task automatic do_reset();
        stable_en = 1'b0;
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        last = RST_RES;
        chk("reset_digits", res_now(), RST_RES);
        chk("reset_busy", 33'(busy), 33'(0));
        chk("reset_done", 33'(done), 33'(0));
        stable_en = 1'b1;
    endtask

    logic [IN_W-1:0] vals [3];
    logic [32:0]     exps [3];

    initial begin
        int   a;
        int   prev;
        int   k;
        bit   was_busy;
        bit   got;
        exp_t e;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        do_reset();

        // Plain conversion with done-latency check
        do_start(14'd1234, {1'b0, 32'h01020304}, a);
        wait_idle();

        // Largest displayable value, then first overflow value
        do_start(14'd9999, {1'b0, 32'h09090909}, a);
        wait_idle();
        do_start(14'd10000, EXP_ERR, a);
        wait_idle();

        // Zero and leading-zero handling
        do_start(14'd0, EXP_0, a);
        wait_idle();
        do_start(14'd42, EXP_42, a);
        wait_idle();

        // Starts during SHIFT cycles 3 and 9 must be ignored
        do_start(14'd500, EXP_500, a);
        repeat (1) tick();
        bin_in = 14'd77; start = 1'b1;
        tick();
        start = 1'b0; bin_in = '0;
        repeat (5) tick();
        bin_in = 14'd77; start = 1'b1;
        tick();
        start = 1'b0; bin_in = '0;
        wait_idle();
        repeat (3) tick();
        chk("no_queued_start", 33'(busy), 33'(0));

        // Reset in SHIFT cycle 5 aborts the conversion without a done
        bin_in = 14'd8888;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        do_reset();
        repeat (20) tick();
        do_start(14'd8888, {1'b0, 32'h08080808}, a);
        wait_idle();

        // Back-to-back with start held high
        vals[0] = 14'd16383; exps[0] = EXP_ERR;
        vals[1] = 14'd7;     exps[1] = EXP_7;
        vals[2] = 14'd1000;  exps[2] = {1'b0, 32'h01000000};
        bin_in  = vals[0];
        start   = 1'b1;
        prev    = 0;
        k       = 0;
        was_busy = busy;
        got     = 1'b1;
        while (k < 3 && got) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (busy && !was_busy) begin
                    got = 1'b1;
                    was_busy = busy;
                    break;
                end
                was_busy = busy;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL b2b_accept_timeout: got no accept want accept %0d", k);
            end else begin
                e.res  = exps[k];
                e.dcyc = cyc + LAT;
                sb.push_back(e);
                if (k > 0) chk("b2b_interval", 33'(cyc - prev), 33'(IN_W + 2));
                prev = cyc;
                if (k < 2) bin_in = vals[k+1];
                else start = 1'b0;
                k++;
            end
        end
        start = 1'b0;
        wait_idle();
        repeat (4) tick();
        chk("scoreboard_empty", 33'(sb.size()), 33'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by time 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_digit_gen
`default_nettype wire
